// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int          BCD_DIG_W  = 4;
  localparam int          INT_DIGITS = 5;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;
  localparam logic [15:0] SAT_VAL    = 16'h9999;
endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble adjust step: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] i_dig,
  output logic [BCD_DIG_W-1:0] o_dig
);
  assign o_dig = (i_dig >= ADJ_THRESH) ? i_dig + ADJ_ADD : i_dig;
endmodule

// File: rtl/bin_to_bcd_conv.sv
// Iterative shift-and-add-3 binary to BCD converter feeding the 4-digit display scanner.
module bin_to_bcd_conv
  import bcd_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_DIGITS*BCD_DIG_W-1:0] bcd_out,
  output logic                            ovf,
  output logic                            done
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = INT_DIGITS * BCD_DIG_W;
  localparam int OUT_W = NUM_DIGITS * BCD_DIG_W;

  state_t            r_state, w_nxt;
  logic [IN_W-1:0]   r_bin_sr;
  logic [BCD_W-1:0]  r_bcd_sr;
  logic [BCD_W-1:0]  w_adj;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;

  assign in_ready = (r_state == IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_bcd_sr[g*BCD_DIG_W +: BCD_DIG_W]),
      .o_dig (w_adj[g*BCD_DIG_W +: BCD_DIG_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nxt = CONV;
      CONV:    if (r_cnt == CNT_W'(1)) w_nxt = LOAD;
      LOAD:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_sr <= '0;
      r_bcd_sr <= '0;
      r_cnt    <= '0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_bin_sr <= in_data;
          r_bcd_sr <= '0;
          r_cnt    <= CNT_W'(IN_W);
        end
        CONV: begin
          // Adjust all digits, then shift the adjusted BCD and binary together.
          {r_bcd_sr, r_bin_sr} <= {w_adj[BCD_W-2:0], r_bin_sr, 1'b0};
          r_cnt <= r_cnt - 1'b1;
        end
        LOAD: begin
          if (r_bcd_sr[BCD_W-1:OUT_W] != '0) begin
            bcd_out <= SAT_VAL;
            ovf     <= 1'b1;
          end else begin
            bcd_out <= r_bcd_sr[OUT_W-1:0];
            ovf     <= 1'b0;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Directed and random checks of bin_to_bcd_conv against a decimal-arithmetic reference.
module tb_bin_to_bcd_conv;
  localparam int IN_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [15:0]     bcd_out;
  logic            ovf;
  logic            done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bin_to_bcd_conv #(.IN_W(IN_W), .NUM_DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_out  (bcd_out),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturate above 9999. Returns {ovf, bcd}.
  function automatic logic [16:0] ref_bcd(input int v);
    logic [16:0] r;
    if (v > 9999) r = {1'b1, 16'h9999};
    else r = {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic send(input logic [IN_W-1:0] v, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    chk("ready_wait", 32'(in_ready), 1);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    acc      = cyc;
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(in_ready), 0);
    chk("done_low_after_accept", 32'(done), 0);
  endtask

  task automatic wait_done(input int acc, output int lat);
    int n;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    lat = cyc - acc;
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic check_result(input string tag, input int v);
    logic [16:0] e;
    logic        nib_ok;
    e = ref_bcd(v);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(e[15:0]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e[16]));
    nib_ok = 1'b1;
    for (int i = 0; i < 4; i++) if (bcd_out[i*4 +: 4] > 4'd9) nib_ok = 1'b0;
    chk({tag, "_nibbles"}, 32'(nib_ok), 1);
  endtask

  task automatic convert(input string tag, input int v, output int acc);
    int lat;
    send(IN_W'(v), acc);
    wait_done(acc, lat);
    chk({tag, "_latency"}, 32'(lat), IN_W + 1);
    chk({tag, "_ready_with_done"}, 32'(in_ready), 1);
    check_result(tag, v);
  endtask

  initial begin
    int acc0, acc1, acc2, lat, nd, v;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_bcd", 32'(bcd_out), 0);
    chk("idle_ovf", 32'(ovf), 0);
    chk("idle_done", 32'(done), 0);

    // Single conversion and one-cycle done
    convert("c1234", 1234, acc0);
    tick();
    chk("done_pulse_width", 32'(done), 0);
    chk("hold_bcd", 32'(bcd_out), 32'h1234);

    // Back-to-back around the saturation boundary
    convert("c9999", 9999, acc0);
    convert("c10000", 10000, acc1);
    convert("c65535", 65535, acc2);
    chk("spacing1", 32'(acc1 - acc0), IN_W + 2);
    chk("spacing2", 32'(acc2 - acc1), IN_W + 2);

    // Valid held high while busy: ignored until ready returns
    in_data = 16'd42; in_valid = 1'b1;
    tick();
    acc0 = cyc;
    in_data = 16'd7;
    nd = 0;
    for (int i = 0; i < IN_W + 1; i++) begin
      tick();
      if (done) nd++;
      if (i < IN_W) chk("busy_bcd_stable", 32'(bcd_out), 32'h9999);
    end
    chk("hold_single_done", 32'(nd), 1);
    chk("hold_done_at_latency", 32'(done), 1);
    check_result("c42", 42);
    tick();
    acc1 = cyc;
    in_valid = 1'b0;
    chk("second_accept_spacing", 32'(acc1 - acc0), IN_W + 2);
    chk("second_busy", 32'(in_ready), 0);
    wait_done(acc1, lat);
    chk("c7_latency", 32'(lat), IN_W + 1);
    check_result("c7", 7);

    // Reset mid-conversion
    send(16'd5555, acc0);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_bcd", 32'(bcd_out), 0);
    chk("abort_ovf", 32'(ovf), 0);
    nd = 0;
    repeat (2) begin tick(); if (done) nd++; end
    rst = 1'b0;
    repeat (20) begin tick(); if (done) nd++; end
    chk("abort_no_done", 32'(nd), 0);
    chk("abort_bcd_after", 32'(bcd_out), 0);
    convert("c100", 100, acc0);

    // Random sweep, biased toward the saturation boundary
    for (int i = 0; i < 2000; i++) begin
      if (i % 4 == 0) v = int'($urandom_range(9990, 10010));
      else            v = int'($urandom_range(0, 65535));
      convert("rnd", v, acc0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
